// File: rtl/sccb_config.sv
// OV7670 power-up configuration sequencer: walks a {reg,value} ROM table
// and issues one 3-phase SCCB write (device ID, register, data) per entry.
//
// Ports:
//   clock, n_rst        system clock, async active-low reset
//   start               one-cycle pulse, begins a pass when idle
//   table_addr          ROM read address
//   table_data          {reg, value}, valid one cycle after table_addr
//   busy, done          pass in progress / pass finished (held)
//   wr_cnt              SCCB writes issued in the current/last pass
//   sioc                SCCB clock
//   siod_out, siod_oe   SCCB data value and drive enable (0 = released)
`timescale 1ns/1ps

module sccb_config #(
   parameter int         SCCB_DIV     = 125,
   parameter logic [7:0] DEV_ID       = 8'h42,
   parameter int         ADDR_BITW    = 8,
   parameter int         DELAY_CYCLES = 100000,
   parameter logic [7:0] DELAY_MARK   = 8'hF0,
   parameter logic [7:0] END_MARK     = 8'hFF
) (
   input  logic                 clock,
   input  logic                 n_rst,
   input  logic                 start,
   output logic [ADDR_BITW-1:0] table_addr,
   input  logic [15:0]          table_data,
   output logic                 busy,
   output logic                 done,
   output logic [ADDR_BITW-1:0] wr_cnt,
   output logic                 sioc,
   output logic                 siod_out,
   output logic                 siod_oe
);

   localparam int QW = (SCCB_DIV > 2) ? $clog2(SCCB_DIV) : 1;
   localparam int DW = (DELAY_CYCLES > 2) ? $clog2(DELAY_CYCLES) : 1;
   localparam logic [QW-1:0] Q_LAST = QW'(SCCB_DIV - 1);
   localparam logic [DW-1:0] D_LAST = DW'(DELAY_CYCLES - 1);
   localparam logic [ADDR_BITW-1:0] A_LAST = '1;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_START,
      S_BYTE,
      S_STOP,
      S_GAP,
      S_DELAY,
      S_FIN
   } state_t;

   state_t                r_state;
   logic [ADDR_BITW-1:0]  r_addr;
   logic [ADDR_BITW-1:0]  r_wr_cnt;
   logic                  r_busy;
   logic                  r_done;
   logic [QW-1:0]         r_qdiv;
   logic [1:0]            r_q;
   logic [4:0]            r_slot;
   logic [23:0]           r_sr;
   logic [DW-1:0]         r_dcnt;
   logic                  r_sioc;
   logic                  r_sdo;
   logic                  r_oe;

   logic       w_bus;
   logic       w_qend;
   logic       w_qlast;
   logic       w_ack;
   logic       w_tbl_last;
   logic [7:0] w_reg;
   logic       w_sioc;
   logic       w_sdo;
   logic       w_oe;

   assign table_addr = r_addr;
   assign wr_cnt     = r_wr_cnt;
   assign busy       = r_busy;
   assign done       = r_done;
   assign sioc       = r_sioc;
   assign siod_out   = r_sdo;
   assign siod_oe    = r_oe;

   assign w_bus = (r_state == S_START) || (r_state == S_BYTE) ||
                  (r_state == S_STOP)  || (r_state == S_GAP);
   assign w_qend     = (r_qdiv == Q_LAST);
   assign w_qlast    = w_qend && (r_q == 2'd3);
   assign w_ack      = (r_slot == 5'd8) || (r_slot == 5'd17) ||
                       (r_slot == 5'd26);
   assign w_tbl_last = (r_addr == A_LAST);
   assign w_reg      = table_data[15:8];

   // Bus levels for the current quarter; registered into the pins below.
   always_comb begin
      w_sioc = 1'b1;
      w_sdo  = 1'b1;
      w_oe   = 1'b1;
      unique case (r_state)
         S_START: begin
            w_sioc = (r_q != 2'd3);
            w_sdo  = (r_q == 2'd0);
         end
         S_BYTE: begin
            w_sioc = r_q[1];
            if (w_ack) begin
               w_oe  = 1'b0;
               w_sdo = 1'b1;
            end else begin
               w_sdo = r_sr[23];
            end
         end
         S_STOP: begin
            w_sioc = (r_q != 2'd0);
            w_sdo  = r_q[1];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge n_rst) begin
      if (!n_rst) begin
         r_state  <= S_IDLE;
         r_addr   <= '0;
         r_wr_cnt <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_qdiv   <= '0;
         r_q      <= 2'd0;
         r_slot   <= 5'd0;
         r_sr     <= 24'd0;
         r_dcnt   <= '0;
         r_sioc   <= 1'b1;
         r_sdo    <= 1'b1;
         r_oe     <= 1'b1;
      end else begin
         r_sioc <= w_sioc;
         r_sdo  <= w_sdo;
         r_oe   <= w_oe;

         // Quarter timing; r_q wraps naturally after quarter 3.
         if (w_bus) begin
            if (w_qend) begin
               r_qdiv <= '0;
               r_q    <= r_q + 2'd1;
            end else begin
               r_qdiv <= r_qdiv + QW'(1);
            end
         end

         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_busy   <= 1'b1;
                  r_done   <= 1'b0;
                  r_addr   <= '0;
                  r_wr_cnt <= '0;
                  r_state  <= S_FETCH;
               end
            end
            S_FETCH: r_state <= S_DECODE;
            S_DECODE: begin
               if (w_reg == END_MARK) begin
                  r_state <= S_FIN;
               end else if (w_reg == DELAY_MARK) begin
                  r_dcnt  <= '0;
                  r_state <= S_DELAY;
               end else begin
                  r_sr    <= {DEV_ID, table_data};
                  r_qdiv  <= '0;
                  r_q     <= 2'd0;
                  r_slot  <= 5'd0;
                  r_state <= S_START;
               end
            end
            S_START: begin
               if (w_qlast) r_state <= S_BYTE;
            end
            S_BYTE: begin
               if (w_qlast) begin
                  if (!w_ack) r_sr <= {r_sr[22:0], 1'b0};
                  if (r_slot == 5'd26) begin
                     r_wr_cnt <= r_wr_cnt + ADDR_BITW'(1);
                     r_state  <= S_STOP;
                  end else begin
                     r_slot <= r_slot + 5'd1;
                  end
               end
            end
            S_STOP: begin
               if (w_qlast) r_state <= S_GAP;
            end
            S_GAP: begin
               if (w_qlast) begin
                  // Last table slot: finish rather than wrap to 0.
                  if (w_tbl_last) begin
                     r_state <= S_FIN;
                  end else begin
                     r_addr  <= r_addr + ADDR_BITW'(1);
                     r_state <= S_FETCH;
                  end
               end
            end
            S_DELAY: begin
               if (r_dcnt == D_LAST) begin
                  if (w_tbl_last) begin
                     r_state <= S_FIN;
                  end else begin
                     r_addr  <= r_addr + ADDR_BITW'(1);
                     r_state <= S_FETCH;
                  end
               end else begin
                  r_dcnt <= r_dcnt + DW'(1);
               end
            end
            S_FIN: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sccb_config.sv
// Self-checking bench for sccb_config: decodes the SCCB bus into frames
// and checks them against hand-written vectors and corner-case sequences.
`timescale 1ns/1ps

module tb_sccb_config;

   localparam logic [26:0] OEM = 27'b111111110_111111110_111111110;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic n_rst  = 1'b0;
   logic start  = 1'b0;
   logic start2 = 1'b0;
   logic sel    = 1'b0;

   logic [7:0]  addr1;
   logic [15:0] data1 = 16'h0;
   logic        busy1, done1, c1, d1, oe1;
   logic [7:0]  wr1;

   logic [1:0]  addr2;
   logic [15:0] data2 = 16'h0;
   logic        busy2, done2, c2, d2, oe2;
   logic [1:0]  wr2;

   logic [15:0] rom1 [256];
   logic [15:0] rom2 [4];

   sccb_config #(
      .SCCB_DIV(2), .DEV_ID(8'h42), .ADDR_BITW(8),
      .DELAY_CYCLES(50), .DELAY_MARK(8'hF0), .END_MARK(8'hFF)
   ) dut (
      .clock(clock), .n_rst(n_rst), .start(start),
      .table_addr(addr1), .table_data(data1),
      .busy(busy1), .done(done1), .wr_cnt(wr1),
      .sioc(c1), .siod_out(d1), .siod_oe(oe1)
   );

   sccb_config #(
      .SCCB_DIV(2), .DEV_ID(8'h42), .ADDR_BITW(2),
      .DELAY_CYCLES(50), .DELAY_MARK(8'hF0), .END_MARK(8'hFF)
   ) dut2 (
      .clock(clock), .n_rst(n_rst), .start(start2),
      .table_addr(addr2), .table_data(data2),
      .busy(busy2), .done(done2), .wr_cnt(wr2),
      .sioc(c2), .siod_out(d2), .siod_oe(oe2)
   );

   // Synchronous ROMs: data one cycle after the address.
   always @(posedge clock) begin
      data1 <= rom1[addr1];
      data2 <= rom2[addr2];
   end

   logic m_c, m_d, m_oe, m_busy, m_done;
   assign m_c    = sel ? c2    : c1;
   assign m_d    = sel ? d2    : d1;
   assign m_oe   = sel ? oe2   : oe1;
   assign m_busy = sel ? busy2 : busy1;
   assign m_done = sel ? done2 : done1;

   // Bus monitor
   logic pc = 1'b1, pd = 1'b1, pdone = 1'b0, pbusy = 1'b0;
   logic in_x = 1'b0, left0 = 1'b0;
   logic [27:0] fr = '0, oem = '0;
   int bitcnt = 0, hcnt = 0, hbad = 0, done_rise = 0, cyc = 0;
   int busy_t0 = 0, busy_len = 0, last_start = 0, abad = 0;
   logic [26:0] fq [$];
   logic [26:0] oq [$];
   int nq [$];

   always @(negedge clock) begin
      cyc <= cyc + 1;
      if (!n_rst) begin
         in_x  <= 1'b0;
         pc    <= 1'b1;
         pd    <= 1'b1;
         pdone <= 1'b0;
         pbusy <= 1'b0;
         left0 <= 1'b0;
      end else begin
         pc    <= m_c;
         pd    <= m_d;
         pdone <= m_done;
         pbusy <= m_busy;
         if (m_done && !pdone) done_rise <= done_rise + 1;
         if (m_busy && !pbusy) busy_t0 <= cyc;
         if (!m_busy && pbusy) busy_len <= cyc - busy_t0;
         if (m_c && pc && pd && !m_d) begin
            in_x       <= 1'b1;
            bitcnt     <= 0;
            last_start <= cyc;
            hcnt       <= -100;
         end else if (in_x && m_c && !pc) begin
            fr     <= {fr[26:0], m_d};
            oem    <= {oem[26:0], m_oe};
            bitcnt <= bitcnt + 1;
            hcnt   <= 1;
         end else if (in_x && m_c && pc && !pd && m_d) begin
            // The STOP's own sioc rise was sampled as a bit; drop it.
            fq.push_back(fr[27:1]);
            oq.push_back(oem[27:1]);
            nq.push_back(bitcnt - 1);
            in_x <= 1'b0;
         end else if (in_x && m_c) begin
            hcnt <= hcnt + 1;
         end
         if (in_x && !m_c && pc && hcnt > 0 && hcnt != 4)
            hbad <= hbad + 1;
         if (!m_busy) left0 <= 1'b0;
         else if (sel && addr2 != 2'd0) left0 <= 1'b1;
         else if (sel && left0) abad <= abad + 1;
      end
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic pulse_start();
      @(posedge clock);
      #1;
      if (sel) start2 = 1'b1;
      else start = 1'b1;
      @(posedge clock);
      #1;
      start  = 1'b0;
      start2 = 1'b0;
   endtask

   task automatic wait_done(input int lim);
      int k;
      k = 0;
      while (!m_done && k < lim) begin
         @(posedge clock);
         k++;
      end
      chk("done_timeout", {63'd0, m_done}, 64'd1);
      repeat (3) @(posedge clock);
      #1;
   endtask

   task automatic chk_frame(input string tag, input int idx,
                            input logic [26:0] ef);
      chk({tag, "_frame"}, (fq.size() > idx) ? 64'(fq[idx]) : 64'hDEAD,
          64'(ef));
      chk({tag, "_ackoe"}, (oq.size() > idx) ? 64'(oq[idx]) : 64'hDEAD,
          64'(OEM));
      chk({tag, "_nbits"}, (nq.size() > idx) ? 64'(nq[idx]) : 64'hDEAD,
          64'd27);
   endtask

   typedef struct {
      logic [7:0]  r;
      logic [7:0]  v;
      logic [26:0] frame;
      logic [7:0]  wr;
      logic [7:0]  addr;
      int          blen;
   } vec_t;

   vec_t vt [4];
   int nb, dr, lat0, hb0;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // busy: fetch+decode (2) + write (240) + end-marker fetch+decode (2)
      // + FIN (1) = 245 cycles.
      vt[0] = '{8'h12, 8'h80, {8'h42, 1'b1, 8'h12, 1'b1, 8'h80, 1'b1},
                8'd1, 8'd1, 245};
      vt[1] = '{8'h2A, 8'h55, {8'h42, 1'b1, 8'h2A, 1'b1, 8'h55, 1'b1},
                8'd1, 8'd1, 245};
      vt[2] = '{8'hFE, 8'h01, {8'h42, 1'b1, 8'hFE, 1'b1, 8'h01, 1'b1},
                8'd1, 8'd1, 245};
      vt[3] = '{8'h00, 8'hFF, {8'h42, 1'b1, 8'h00, 1'b1, 8'hFF, 1'b1},
                8'd1, 8'd1, 245};
      for (int i = 0; i < 256; i++) rom1[i] = 16'hFF00;
      for (int i = 0; i < 4; i++) rom2[i] = 16'h0000;

      repeat (3) @(posedge clock);
      #1;
      chk("rst_addr", 64'(addr1), 64'd0);
      chk("rst_busy", 64'(busy1), 64'd0);
      chk("rst_done", 64'(done1), 64'd0);
      chk("rst_wrcnt", 64'(wr1), 64'd0);
      chk("rst_sioc", 64'(c1), 64'd1);
      chk("rst_siod", 64'(d1), 64'd1);
      chk("rst_oe", 64'(oe1), 64'd1);
      n_rst = 1'b1;
      repeat (2) @(posedge clock);

      lat0 = 0;
      for (int i = 0; i < 4; i++) begin
         rom1[0] = {vt[i].r, vt[i].v};
         rom1[1] = 16'hFF00;
         nb = fq.size();
         dr = done_rise;
         pulse_start();
         wait_done(2000);
         if (i == 0) lat0 = last_start - busy_t0;
         chk("vec_nframes", 64'(fq.size()), 64'(nb + 1));
         chk_frame("vec", nb, vt[i].frame);
         chk("vec_wrcnt", 64'(wr1), 64'(vt[i].wr));
         chk("vec_addr", 64'(addr1), 64'(vt[i].addr));
         chk("vec_done", 64'(done1), 64'd1);
         chk("vec_busy", 64'(busy1), 64'd0);
         chk("vec_busylen", 64'(busy_len), 64'(vt[i].blen));
         chk("vec_donerise", 64'(done_rise), 64'(dr + 1));
         chk("vec_idle_bus", 64'({c1, d1, oe1}), 64'h7);
      end
      chk("sioc_high_time", 64'(hbad), 64'd0);

      // Delay marker: extra entry costs fetch+decode (2) + 50 idle cycles.
      rom1[0] = 16'hF000;
      rom1[1] = 16'h1101;
      rom1[2] = 16'hFF00;
      nb = fq.size();
      pulse_start();
      wait_done(2000);
      chk("dly_nframes", 64'(fq.size()), 64'(nb + 1));
      chk_frame("dly", nb, {8'h42, 1'b1, 8'h11, 1'b1, 8'h01, 1'b1});
      chk("dly_wrcnt", 64'(wr1), 64'd1);
      chk("dly_latency", 64'(last_start - busy_t0 - lat0), 64'd52);
      chk("dly_busylen", 64'(busy_len), 64'd297);
      chk("dly_addr", 64'(addr1), 64'd2);

      // start pulsed mid-pass is ignored.
      rom1[0] = 16'h1280;
      rom1[1] = 16'hFF00;
      nb = fq.size();
      dr = done_rise;
      pulse_start();
      repeat (100) @(posedge clock);
      pulse_start();
      wait_done(2000);
      chk("mid_nframes", 64'(fq.size()), 64'(nb + 1));
      chk_frame("mid", nb, {8'h42, 1'b1, 8'h12, 1'b1, 8'h80, 1'b1});
      chk("mid_wrcnt", 64'(wr1), 64'd1);
      chk("mid_donerise", 64'(done_rise), 64'(dr + 1));
      chk("mid_busylen", 64'(busy_len), 64'd245);

      // Async reset in the middle of a data byte.
      rom1[0] = 16'h3355;
      rom1[1] = 16'hFF00;
      nb = fq.size();
      pulse_start();
      repeat (60) @(posedge clock);
      #2;
      n_rst = 1'b0;
      #1;
      chk("arst_addr", 64'(addr1), 64'd0);
      chk("arst_busy", 64'(busy1), 64'd0);
      chk("arst_done", 64'(done1), 64'd0);
      chk("arst_wrcnt", 64'(wr1), 64'd0);
      chk("arst_bus", 64'({c1, d1, oe1}), 64'h7);
      repeat (2) @(posedge clock);
      #1;
      n_rst = 1'b1;
      repeat (2) @(posedge clock);
      chk("arst_noframe", 64'(fq.size()), 64'(nb));
      pulse_start();
      wait_done(2000);
      chk("arst_nframes", 64'(fq.size()), 64'(nb + 1));
      chk_frame("arst", nb, {8'h42, 1'b1, 8'h33, 1'b1, 8'h55, 1'b1});
      chk("arst_wrcnt2", 64'(wr1), 64'd1);

      // 2-bit table with no end marker: 4 writes, then stop at addr 3.
      // wr_cnt is 2 bits wide, so 4 writes read back as 0.
      rom2[0] = 16'hA000;
      rom2[1] = 16'hA111;
      rom2[2] = 16'hA222;
      rom2[3] = 16'hA333;
      sel = 1'b1;
      repeat (2) @(posedge clock);
      nb = fq.size();
      dr = done_rise;
      hb0 = hbad;
      pulse_start();
      wait_done(5000);
      chk("wrap_nframes", 64'(fq.size()), 64'(nb + 4));
      chk_frame("wrap0", nb, {8'h42, 1'b1, 8'hA0, 1'b1, 8'h00, 1'b1});
      chk_frame("wrap3", nb + 3, {8'h42, 1'b1, 8'hA3, 1'b1, 8'h33, 1'b1});
      chk("wrap_wrcnt", 64'(wr2), 64'd0);
      chk("wrap_addr", 64'(addr2), 64'd3);
      chk("wrap_done", 64'(done2), 64'd1);
      chk("wrap_donerise", 64'(done_rise), 64'(dr + 1));
      chk("wrap_addr0", 64'(abad), 64'd0);
      chk("wrap_sioc_high", 64'(hbad), 64'(hb0));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sccb_config.md
Name: sccb_config

Overview:
Sequencer that configures the OV7670 at power-up over SCCB before camera_if output is trusted. On a start pulse it walks an external register table of {reg, value} entries and issues one 3-phase SCCB write per entry: device ID, register address, data. It honours in-table delay and end markers, then reports done. It sits beside the camera interface in the camera top level and shares its system clock.

Parameters:
SCCB_DIV, 125, clock cycles per SIOC quarter-period (100 MHz gives 200 kHz SIOC); legal minimum 2
DEV_ID, 8'h42, SCCB write device ID
ADDR_BITW, 8, table address width
DELAY_CYCLES, 100000, wait length for a delay-marker entry, in clock cycles
DELAY_MARK, 8'hF0, reg value that marks a delay entry (the value field is ignored)
END_MARK, 8'hFF, reg value that marks end of table

Ports:
clock  in  1  system clock
n_rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse that begins a configuration pass
table_addr  out  ADDR_BITW  table read address
table_data  in  16  {reg[15:8], value[7:0]}, valid exactly 1 cycle after table_addr changes (synchronous ROM)
busy  out  1  high while a pass is in progress
done  out  1  high after a pass completes; held until the next accepted start
wr_cnt  out  ADDR_BITW  number of SCCB writes issued in the current/last pass
sioc  out  1  SCCB clock
siod_out  out  1  SCCB data value
siod_oe  out  1  SCCB data drive enable (0 = released)

Behaviour:
- Clock is `clock`. Reset `n_rst` is asynchronous and active-low.
- Reset values: table_addr=0, busy=0, done=0, wr_cnt=0, sioc=1, siod_out=1, siod_oe=1. State is IDLE.
- Quarter tick: a counter runs 0..SCCB_DIV-1 while in bus states. Each quarter lasts exactly SCCB_DIV cycles.
- States: IDLE, FETCH, DECODE, START, BYTE, STOP, GAP, DELAY, FIN.
- IDLE: start=1 sets busy=1, done=0, table_addr=0, wr_cnt=0, then goes to FETCH. start while busy is ignored.
- FETCH: 1 cycle wait for ROM latency, then DECODE.
- DECODE: 1 cycle. reg==END_MARK goes to FIN. reg==DELAY_MARK goes to DELAY. Otherwise latch {DEV_ID, reg, value} into a 24-bit shift register and go to START.
- START (4 quarters, sioc/siod): 1/1, 1/0, 1/0, 0/0.
- BYTE: 27 bit slots of 4 quarters each.
  - Per slot, sioc is 0,0,1,1. siod changes only at the slot's first quarter.
  - Slots 0-7, 9-16 and 18-25 drive shift-register bits MSB first.
  - Slots 8, 17 and 26 are don't-care: siod_oe=0, siod_out=1. The ack is not sampled.
- STOP (4 quarters): 0/0, 1/0, 1/1, 1/1. wr_cnt increments on entry to STOP.
- GAP: 4 quarters with sioc=1, siod=1. Then table_addr increments and the block goes to FETCH.
- One write therefore costs 2 + 120*SCCB_DIV cycles, from FETCH entry to the next FETCH entry.
- DELAY: waits DELAY_CYCLES cycles with the bus idle. Then table_addr increments and the block goes to FETCH. wr_cnt is unchanged.
- Address wrap: if the entry at address 2^ADDR_BITW-1 is processed without reaching END_MARK, go to FIN instead of wrapping. No wrap-around ever occurs.
- FIN: 1 cycle, sets busy=0 and done=1, then IDLE. A start in the cycle after FIN is accepted normally.
- Bus outside transactions: sioc=1, siod_out=1, siod_oe=1.
- An asynchronous reset mid-transaction returns everything to reset values immediately. No stop condition is generated; the next pass's START resynchronises the sensor.

Test Plan:
- SCCB_DIV=2, table {12 80}, {FF xx}; start pulse. Expect one write with bit stream 0x42, 0x12, 0x80 and siod_oe=0 in the three ack slots. wr_cnt=1, done=1, and busy high for 2+240+FIN cycles.
- Start/stop shape: siod falls while sioc=1 at START and rises while sioc=1 at STOP. sioc high time is 2 quarters per bit, measured as 4 cycles at SCCB_DIV=2.
- Delay marker: table {F0 00}, {11 01}, {FF 00}, DELAY_CYCLES=50. Bus stays idle for 50 cycles, then one write to reg 0x11. wr_cnt=1.
- start pulsed mid-pass: ignored. wr_cnt and the stream are unaffected, and done is asserted only once.
- ADDR_BITW=2, table without END_MARK: exactly 4 writes, then done=1. table_addr never returns to 0 during the pass.
- n_rst asserted in the middle of a data byte: outputs equal reset values within the same cycle. A new start then produces a complete, correct first write.
